regfile_write_sequencer: RTL and testbench

- Arbitrates two write requesters (A: ALU result path, B: bus load path) onto the single shared write port of the 4x8 dual-port register file.
- Generates the level-sensitive, active-low write strobe with programmable address/data setup, pulse and hold windows.
- Tracks a per-register pending bitmap so the left and right read ports can stall on read-after-write hazards.

---
 rtl/regfile_write_sequencer.sv | 161 ++++++++++++++++
 tb/tb_regfile_write_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_sequencer.sv
// Write-port sequencer for the 4x8 dual-port register file.
// Arbitrates ALU (A) and bus-load (B) writers, shapes the _rf_we strobe, tracks RAW hazards.
module regfile_write_sequencer #(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       _MR,
  input  logic       reqA,
  input  logic [1:0] addrA,
  input  logic [7:0] dataA,
  output logic       ackA,
  input  logic       reqB,
  input  logic [1:0] addrB,
  input  logic [7:0] dataB,
  output logic       ackB,
  output logic [1:0] rf_wr_addr,
  output logic [7:0] rf_wr_data,
  output logic       _rf_we,
  output logic       busy,
  output logic [3:0] pend,
  input  logic [1:0] rdL_addr,
  input  logic [1:0] rdR_addr,
  output logic       rdL_stall,
  output logic       rdR_stall
);

  localparam int S_EFF = (SETUP_CYCLES < 1) ? 1 : SETUP_CYCLES;
  localparam int P_EFF = (PULSE_CYCLES < 1) ? 1 : PULSE_CYCLES;
  localparam int H_EFF = (HOLD_CYCLES  < 1) ? 1 : HOLD_CYCLES;

  localparam int M_SP = (S_EFF > P_EFF) ? S_EFF : P_EFF;
  localparam int MAXC = (M_SP > H_EFF) ? M_SP : H_EFF;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] S_LD = CW'(S_EFF - 1);
  localparam logic [CW-1:0] P_LD = CW'(P_EFF - 1);
  localparam logic [CW-1:0] H_LD = CW'(H_EFF - 1);
  localparam logic          H_ONE = (H_EFF == 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we_n;
  logic          r_ackA;
  logic          r_ackB;
  logic          r_busy;
  logic [3:0]    r_pend;
  logic [1:0]    r_addr;
  logic [7:0]    r_data;
  logic          r_last_b;
  logic          r_gnt_b;

  logic          w_any;
  logic          w_grant_b;
  logic [1:0]    w_gnt_addr;
  logic [7:0]    w_gnt_data;
  logic [3:0]    w_gnt_dec;
  logic          w_cnt_zero;
  logic          w_cnt_one;

  // Grant B when it is the only requester, or on a tie when A won last time.
  assign w_any      = reqA | reqB;
  assign w_grant_b  = reqB & (~reqA | ~r_last_b);
  assign w_gnt_addr = w_grant_b ? addrB : addrA;
  assign w_gnt_data = w_grant_b ? dataB : dataA;
  assign w_gnt_dec  = 4'b0001 << w_gnt_addr;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_one  = (r_cnt == CW'(1));

  // Sequencer: grant, setup, strobe, hold, with all outputs registered.
  always_ff @(posedge clk or negedge _MR) begin
    if (!_MR) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_we_n   <= 1'b1;
      r_ackA   <= 1'b0;
      r_ackB   <= 1'b0;
      r_busy   <= 1'b0;
      r_pend   <= 4'b0000;
      r_addr   <= 2'b00;
      r_data   <= 8'h00;
      r_last_b <= 1'b1;
      r_gnt_b  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state  <= SETUP;
            r_cnt    <= S_LD;
            r_gnt_b  <= w_grant_b;
            r_last_b <= w_grant_b;
            r_addr   <= w_gnt_addr;
            r_data   <= w_gnt_data;
            r_pend   <= w_gnt_dec;
            r_busy   <= 1'b1;
          end
        end
        SETUP: begin
          if (w_cnt_zero) begin
            r_state <= STROBE;
            r_cnt   <= P_LD;
            r_we_n  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        STROBE: begin
          if (w_cnt_zero) begin
            r_state <= HOLD;
            r_cnt   <= H_LD;
            r_we_n  <= 1'b1;
            r_ackA  <= H_ONE & ~r_gnt_b;
            r_ackB  <= H_ONE & r_gnt_b;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        HOLD: begin
          if (w_cnt_zero) begin
            r_state <= IDLE;
            r_ackA  <= 1'b0;
            r_ackB  <= 1'b0;
            r_pend  <= 4'b0000;
            r_busy  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt - CW'(1);
            r_ackA <= w_cnt_one & ~r_gnt_b;
            r_ackB <= w_cnt_one & r_gnt_b;
          end
        end
        default: begin
          r_state <= IDLE;
          r_we_n  <= 1'b1;
          r_ackA  <= 1'b0;
          r_ackB  <= 1'b0;
          r_pend  <= 4'b0000;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ackA       = r_ackA;
  assign ackB       = r_ackB;
  assign rf_wr_addr = r_addr;
  assign rf_wr_data = r_data;
  assign _rf_we     = r_we_n;
  assign busy       = r_busy;
  assign pend       = r_pend;
  assign rdL_stall  = r_pend[rdL_addr];
  assign rdR_stall  = r_pend[rdR_addr];

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed bench for regfile_write_sequencer.
// Default-timing instance plus a SETUP=2/PULSE=3/HOLD=0 instance.
module tb_regfile_write_sequencer;

  logic       clk;
  logic       mr_n;

  logic       reqA, reqB;
  logic [1:0] addrA, addrB;
  logic [7:0] dataA, dataB;
  logic       ackA, ackB;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       we_n;
  logic       busy;
  logic [3:0] pend;
  logic [1:0] rdL, rdR;
  logic       stL, stR;

  logic       v_reqA, v_reqB;
  logic [1:0] v_addrA, v_addrB;
  logic [7:0] v_dataA, v_dataB;
  logic       v_ackA, v_ackB;
  logic [1:0] v_wr_addr;
  logic [7:0] v_wr_data;
  logic       v_we_n;
  logic       v_busy;
  logic [3:0] v_pend;
  logic [1:0] v_rdL, v_rdR;
  logic       v_stL, v_stR;

  int tests = 0;
  int fails = 0;

  regfile_write_sequencer dut (
    .clk(clk), ._MR(mr_n),
    .reqA(reqA), .addrA(addrA), .dataA(dataA), .ackA(ackA),
    .reqB(reqB), .addrB(addrB), .dataB(dataB), .ackB(ackB),
    .rf_wr_addr(wr_addr), .rf_wr_data(wr_data), ._rf_we(we_n),
    .busy(busy), .pend(pend),
    .rdL_addr(rdL), .rdR_addr(rdR),
    .rdL_stall(stL), .rdR_stall(stR)
  );

  regfile_write_sequencer #(
    .SETUP_CYCLES(2), .PULSE_CYCLES(3), .HOLD_CYCLES(0)
  ) dut_v (
    .clk(clk), ._MR(mr_n),
    .reqA(v_reqA), .addrA(v_addrA), .dataA(v_dataA), .ackA(v_ackA),
    .reqB(v_reqB), .addrB(v_addrB), .dataB(v_dataB), .ackB(v_ackB),
    .rf_wr_addr(v_wr_addr), .rf_wr_data(v_wr_data), ._rf_we(v_we_n),
    .busy(v_busy), .pend(v_pend),
    .rdL_addr(v_rdL), .rdR_addr(v_rdR),
    .rdL_stall(v_stL), .rdR_stall(v_stR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reqA = 0; reqB = 0; addrA = 0; addrB = 0; dataA = 0; dataB = 0;
    rdL = 0; rdR = 0;
    v_reqA = 0; v_reqB = 0; v_addrA = 0; v_addrB = 0;
    v_dataA = 0; v_dataB = 0; v_rdL = 0; v_rdR = 0;
    mr_n = 1'b1;
    #1 mr_n = 1'b0;
    #20;
    chk("rst_we", 32'(we_n), 32'h1);
    chk("rst_ackA", 32'(ackA), 32'h0);
    chk("rst_ackB", 32'(ackB), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pend", 32'(pend), 32'h0);
    chk("rst_addr", 32'(wr_addr), 32'h0);
    chk("rst_data", 32'(wr_data), 32'h0);
    chk("rst_v_we", 32'(v_we_n), 32'h1);
    mr_n = 1'b1;

    // single write from A
    reqA = 1; addrA = 2; dataA = 8'h5A;
    step();
    chk("sw1_addr", 32'(wr_addr), 32'h2);
    chk("sw1_data", 32'(wr_data), 32'h5A);
    chk("sw1_we", 32'(we_n), 32'h1);
    chk("sw1_pend", 32'(pend), 32'h4);
    chk("sw1_ack", 32'(ackA), 32'h0);
    chk("sw1_busy", 32'(busy), 32'h1);
    step();
    chk("sw2_we", 32'(we_n), 32'h0);
    chk("sw2_pend", 32'(pend), 32'h4);
    chk("sw2_ack", 32'(ackA), 32'h0);
    step();
    chk("sw3_ackA", 32'(ackA), 32'h1);
    chk("sw3_ackB", 32'(ackB), 32'h0);
    chk("sw3_we", 32'(we_n), 32'h1);
    chk("sw3_pend", 32'(pend), 32'h4);
    chk("sw3_data", 32'(wr_data), 32'h5A);
    reqA = 0;
    step();
    chk("sw4_pend", 32'(pend), 32'h0);
    chk("sw4_ack", 32'(ackA), 32'h0);
    chk("sw4_busy", 32'(busy), 32'h0);

    // RAW stall on register 1
    reqB = 1; addrB = 1; dataB = 8'h77; rdL = 1; rdR = 3;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("raw_stL", 32'(stL), (c <= 3) ? 32'h1 : 32'h0);
      chk("raw_stR", 32'(stR), 32'h0);
      if (c == 3) begin
        chk("raw_ackB", 32'(ackB), 32'h1);
        reqB = 0;
      end
    end
    rdL = 0; rdR = 0;

    // back-to-back writes from B
    reqB = 1; addrB = 0; dataB = 8'h33;
    step(); step(); step();
    chk("b2b_ack1", 32'(ackB), 32'h1);
    chk("b2b_addr1", 32'(wr_addr), 32'h0);
    addrB = 3; dataB = 8'h44;
    step();
    chk("b2b_idle", 32'(busy), 32'h0);
    chk("b2b_idle_ack", 32'(ackB), 32'h0);
    step();
    chk("b2b_busy2", 32'(busy), 32'h1);
    chk("b2b_addr2", 32'(wr_addr), 32'h3);
    chk("b2b_data2", 32'(wr_data), 32'h44);
    chk("b2b_pend2", 32'(pend), 32'h8);
    step(); step();
    chk("b2b_ack2", 32'(ackB), 32'h1);
    reqB = 0;
    step();
    chk("b2b_done", 32'(busy), 32'h0);

    // contention after reset: A, B, A, B
    mr_n = 1'b0;
    #2 mr_n = 1'b1;
    reqA = 1; addrA = 0; dataA = 8'h11;
    reqB = 1; addrB = 3; dataB = 8'h22;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk("cont_ackA", 32'(ackA), (c == 3 || c == 11) ? 32'h1 : 32'h0);
      chk("cont_ackB", 32'(ackB), (c == 7 || c == 15) ? 32'h1 : 32'h0);
      if (c == 1 || c == 9) chk("cont_addrA", 32'(wr_addr), 32'h0);
      if (c == 5 || c == 13) chk("cont_addrB", 32'(wr_addr), 32'h3);
      if (c == 15) begin
        reqA = 0;
        reqB = 0;
      end
    end

    // reset mid-strobe of an A write; next tie must go to A
    reqA = 1; addrA = 1; dataA = 8'h99;
    step();
    step();
    chk("mr_we_low", 32'(we_n), 32'h0);
    mr_n = 1'b0;
    #1;
    chk("mr_we", 32'(we_n), 32'h1);
    chk("mr_pend", 32'(pend), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_ackA", 32'(ackA), 32'h0);
    #2 mr_n = 1'b1;
    reqB = 1; addrB = 2; dataB = 8'hBB;
    step();
    chk("mr_gnt_addr", 32'(wr_addr), 32'h1);
    chk("mr_gnt_data", 32'(wr_data), 32'h99);
    step(); step();
    chk("mr_ackA2", 32'(ackA), 32'h1);
    chk("mr_ackB2", 32'(ackB), 32'h0);
    reqA = 0; reqB = 0;
    step();
    chk("mr_idle", 32'(busy), 32'h0);

    // SETUP=2, PULSE=3, HOLD=0 instance
    v_reqA = 1; v_addrA = 1; v_dataA = 8'hC3;
    for (int c = 1; c <= 7; c++) begin
      step();
      chk("var_we", 32'(v_we_n), (c >= 3 && c <= 5) ? 32'h0 : 32'h1);
      chk("var_ack", 32'(v_ackA), (c == 6) ? 32'h1 : 32'h0);
      if (c <= 6) begin
        chk("var_addr", 32'(v_wr_addr), 32'h1);
        chk("var_data", 32'(v_wr_data), 32'hC3);
        chk("var_pend", 32'(v_pend), 32'h2);
      end
      if (c == 6) v_reqA = 0;
      if (c == 7) chk("var_busy", 32'(v_busy), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
